scan_display_counter: RTL
=========================

# scan_display_counter

Parametrised N-digit up/down counter with a built-in time-multiplexed seven-segment scanner, for driving external common-cathode multi-digit displays from GPIO. It generalises the fixed 4-digit free-running display path: a configurable digit count, a decimal or hex counting mode, a prescaled count rate, synchronous load, direction control, and a scanner with an inter-digit blanking interval to suppress ghosting. It sits between board switches/keys and the GPIO display header.

## Interface
- DIGITS, 4, number of digits/nibbles (1..8)
- BCD, 1, 1 = decimal digits 0-9, 0 = hex digits 0-F
- PRESCALE, 5000000, CLOCK_50 cycles per count step (>=1)
- SCAN_DIV, 50000, cycles each digit is driven (>=1)
- BLANK_CYCLES, 16, all-off cycles between digits (>=0)

- CLOCK_50  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  count enable; gates prescaler
- up  in  1  1 = increment, 0 = decrement
- load  in  1  synchronous load strobe
- load_val  in  4*DIGITS  value loaded on load
- count  out  4*DIGITS  current count, nibble i = digit i
- wrap  out  1  one-cycle pulse on roll-over/under
- seg  out  7  segments, active-high, bit0 = a ... bit6 = g
- sel  out  DIGITS  one-hot digit select, active-high

## Operation
- Reset: count=0, prescaler=0, wrap=0, seg=0, sel=0, scan state DRIVE, index 0, scan counter 0.
- Prescaler: when en=1 counts 0..PRESCALE-1, then wraps to 0 and issues internal tick in that cycle; en=0 holds it. PRESCALE=1 ticks every enabled cycle.
- Count step on tick: up=1 adds 1, up=0 subtracts 1.
  - BCD=1: each nibble 0..9 with decimal carry/borrow ripple; all-9s +1 -> 0, 0 -1 -> all-9s.
  - BCD=0: plain binary modulo 16^DIGITS.
  - wrap=1 for exactly the cycle following a roll-over/under step (registered alongside count).
- Load: load=1 sets count=load_val and clears prescaler; load has priority over a coincident tick (no step, wrap=0). BCD=1: any loaded nibble >9 stored as 9.
- Scanner FSM, independent of en:
  - DRIVE: sel one-hot at index i, seg = glyph(count nibble i); held SCAN_DIV cycles.
  - BLANK: sel=0, seg=0; held BLANK_CYCLES cycles; skipped when BLANK_CYCLES=0.
  - After BLANK (or DRIVE if skipped): i = (i+1) mod DIGITS, enter DRIVE.
- Glyphs: 0-9 standard; hex A b C d E F; 0 = 0x3F, 1 = 0x06, 8 = 0x7F, F = 0x71.
- seg tracks count live during DRIVE: a count change mid-slot updates seg next cycle.
- Reset asserted mid-operation overrides everything in the same edge.

## Timing
- count/wrap: registered; step visible the cycle after the tick cycle.
- seg/sel: registered; 1-cycle latency from FSM state/count to pins.
- First edge after reset deasserted: sel=1 (digit 0), seg=glyph(0)=0x3F.
- Scan period = DIGITS*(SCAN_DIV+BLANK_CYCLES) cycles; each digit sel high for exactly SCAN_DIV consecutive cycles.
- sel never has more than one bit set; sel and seg change on the same edge.

## Configuration
- SCAN_DISPLAY_LZB_EN defined: leading-zero blanking. In DRIVE, digit i>0 shows seg=0 (sel still asserted) when nibble i and all higher nibbles are 0; digit 0 always shown.
- Undefined: every digit shows its glyph, including leading zeros.

## Test plan
- Params DIGITS=4, PRESCALE=4, SCAN_DIV=3, BLANK_CYCLES=1, BCD=1, en=1, up=1, from reset -> count steps every 4 cycles: 0000, 0001, ... 0009, 0010.
- load_val=0x9999, then 1 tick up -> count=0x0000, wrap high one cycle; down from 0x0000 -> 0x9999, wrap high.
- load_val=0x1A3F with BCD=1 -> count=0x1939; BCD=0 load 0xFFFF, up -> 0x0000 with wrap.
- Scanner from reset -> sel sequence 0001x3, 0000x1, 0010x3, 0000x1, 0100x3, 0000x1, 1000x3, 0000x1, repeating; seg=0x3F on every driven slot (0x3F on digit 0 only, 0 elsewhere, with SCAN_DISPLAY_LZB_EN).
- load and tick in same cycle with load_val=0x0005 -> count=0x0005, no extra step; reset mid-count -> next cycle count=0, sel=0, seg=0, wrap=0.
- en=0 for 20 cycles -> count frozen, scanner keeps cycling sel.

Source files
------------

// File: rtl/scan_display_counter.sv
// N-digit BCD/hex up/down counter with a multiplexed seven-segment scanner.
// Optional leading-zero blanking when SCAN_DISPLAY_LZB_EN is defined.
module scan_display_counter #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned BCD          = 1,
  parameter int unsigned PRESCALE     = 5000000,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     sel
);

  localparam int unsigned CW   = 4 * DIGITS;
  localparam int unsigned PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int unsigned SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0]  DMAX = (BCD != 0) ? 4'd9 : 4'd15;

  typedef enum logic {DRIVE, BLANK} scan_state_t;

  logic [PW-1:0]   psc;
  logic            tick;
  logic [CW-1:0]   stepped;
  logic [CW-1:0]   loaded;
  logic            roll;
  logic [3:0]      step_nib;
  logic            carry;

  scan_state_t     state, state_next;
  logic [IW-1:0]   idx, idx_next, idx_inc;
  logic [SW-1:0]   scnt, scnt_next;
  logic [3:0]      cur_nib;
  logic [DIGITS-1:0] lead_zero;
  logic            above_zero;
  logic            blank_digit;
  logic [6:0]      seg_next;
  logic [DIGITS-1:0] sel_next;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  assign tick = en && (psc == PW'(PRESCALE - 1));

  // Ripple carry/borrow across nibbles; carry out of the top digit is a roll-over.
  always_comb begin
    stepped  = count;
    carry    = 1'b1;
    step_nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      step_nib = count[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (step_nib >= DMAX) step_nib = 4'd0;
          else begin
            step_nib = step_nib + 4'd1;
            carry    = 1'b0;
          end
        end else begin
          if (step_nib == 4'd0) step_nib = DMAX;
          else begin
            step_nib = step_nib - 4'd1;
            carry    = 1'b0;
          end
        end
      end
      stepped[4*i +: 4] = step_nib;
    end
    roll = carry;
  end

  // Loaded digits saturate at 9 in decimal mode.
  always_comb begin
    loaded = load_val;
    if (BCD != 0) begin
      for (int i = 0; i < DIGITS; i++)
        if (load_val[4*i +: 4] > 4'd9) loaded[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
      psc   <= '0;
    end else if (load) begin
      count <= loaded;
      wrap  <= 1'b0;
      psc   <= '0;
    end else begin
      if (en) psc <= tick ? '0 : psc + PW'(1);
      if (tick) begin
        count <= stepped;
        wrap  <= roll;
      end else begin
        wrap  <= 1'b0;
      end
    end
  end

  // lead_zero[i]: nibble i and every nibble above it are zero.
  always_comb begin
    above_zero = 1'b1;
    lead_zero  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      above_zero   = above_zero && (count[4*i +: 4] == 4'd0);
      lead_zero[i] = above_zero;
    end
  end

  always_comb begin
    cur_nib     = 4'd0;
    blank_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = count[4*i +: 4];
`ifdef SCAN_DISPLAY_LZB_EN
        blank_digit = (i != 0) && lead_zero[i];
`endif
      end
    end
  end

  assign idx_inc = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= DRIVE;
      idx   <= '0;
      scnt  <= '0;
      seg   <= '0;
      sel   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      scnt  <= scnt_next;
      seg   <= seg_next;
      sel   <= sel_next;
    end
  end

  // Scanner next state and pin values; pins lag the state by one cycle.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    scnt_next  = scnt + SW'(1);
    seg_next   = 7'd0;
    sel_next   = '0;
    case (state)
      DRIVE: begin
        sel_next = DIGITS'(1) << idx;
        seg_next = blank_digit ? 7'd0 : glyph(cur_nib);
        if (scnt == SW'(SCAN_DIV - 1)) begin
          scnt_next = '0;
          if (BLANK_CYCLES == 0) idx_next = idx_inc;
          else state_next = BLANK;
        end
      end
      default: begin
        if (scnt == SW'(BLANK_CYCLES - 1)) begin
          scnt_next  = '0;
          state_next = DRIVE;
          idx_next   = idx_inc;
        end
      end
    endcase
  end

endmodule
